// File: rtl/pic_pkg.sv
// pic_pkg: shared constants for the PIC interrupt request register
package pic_pkg;
    localparam logic LE_LEVEL = 1'b0;
    localparam logic LE_EDGE = 1'b1;
    localparam int N_IRQ_DEFAULT = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/irr_latch_bank_if.sv
// irr_latch_bank_if: request pins, per-channel control and IRR outputs of the interrupt request register
interface irr_latch_bank_if #(
    parameter int N_IRQ = pic_pkg::N_IRQ_DEFAULT
);
    localparam int ID_W = $clog2(N_IRQ);
    logic [N_IRQ-1:0] i_wires, level_edge_flag, mask, irr_raw, irr;
    logic ack_valid, clear_all, irq_any;
    logic [ID_W-1:0] ack_id;
    modport master(
        output i_wires, level_edge_flag, mask, ack_valid, ack_id, clear_all,
        input irr_raw, irr, irq_any
    );
    modport slave(
        input i_wires, level_edge_flag, mask, ack_valid, ack_id, clear_all,
        output irr_raw, irr, irq_any
    );
endinterface

// File: rtl/irr_sync.sv
// irr_sync: one-bit multi-flop synchroniser for an asynchronous request pin
module irr_sync #(
    parameter int STAGES = pic_pkg::SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/irr_latch_bank.sv
// irr_latch_bank: synchronised interrupt request register with per-channel level/edge mode,
// edge latching until acknowledged, and output masking toward the priority resolver
module irr_latch_bank
    import pic_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    irr_latch_bank_if.slave bus
);
    localparam int ID_W = $clog2(N_IRQ);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int CNT_W = $clog2(ARM_MAX + 1);
    logic [N_IRQ-1:0] s, prev, mode, latch, latch_nxt, rise, clr, ack_hit, mode_chg, irr_raw;
    logic [CNT_W-1:0] arm_cnt;
    logic armed;
    for (genvar i = 0; i < N_IRQ; i++) begin : g_ch
        irr_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk(clk),
            .rst_n(rst_n),
            .d(bus.i_wires[i]),
            .q(s[i])
        );
        // ids at or above N_IRQ never match any channel
        assign ack_hit[i] = bus.ack_valid && bus.ack_id == ID_W'(i);
    end
    // edge detection waits until the sync chain and prev hold real pin values
    assign armed = arm_cnt == CNT_W'(ARM_MAX);
    assign mode_chg = bus.level_edge_flag ^ mode;
    assign rise = {N_IRQ{armed}} & s & ~prev & bus.level_edge_flag & ~mode_chg;
    assign clr = ack_hit | {N_IRQ{bus.clear_all}} | mode_chg | ~bus.level_edge_flag;
    assign latch_nxt = rise | (latch & ~clr);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            mode <= '0;
            latch <= '0;
            irr_raw <= '0;
            arm_cnt <= '0;
        end else begin
            prev <= s;
            mode <= bus.level_edge_flag;
            latch <= latch_nxt;
            irr_raw <= (bus.level_edge_flag & latch_nxt) | (~bus.level_edge_flag & s);
            arm_cnt <= armed ? arm_cnt : arm_cnt + 1'b1;
        end
    end
    assign bus.irr_raw = irr_raw;
    assign bus.irr = irr_raw & ~bus.mask;
    assign bus.irq_any = |bus.irr;
endmodule

// File: tb/tb_irr_latch_bank.sv
// tb_irr_latch_bank: vector table with scoreboard for an 8-channel bank, plus hand sequences
// for combinational masking, a 16-channel bank and asynchronous reset
module tb_irr_latch_bank;
    import pic_pkg::*;
    typedef struct {
        logic [7:0] wires, le, mask;
        logic av;
        logic [2:0] id;
        logic ca;
        logic [7:0] raw;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int passed = 0, total = 0;
    vec_t tv[$];
    vec_t sb[$];
    vec_t e;
    localparam logic [7:0] ALL_EDGE = {8{LE_EDGE}};
    irr_latch_bank_if #(.N_IRQ(8)) bus8 ();
    irr_latch_bank_if #(.N_IRQ(16)) bus16 ();
    irr_latch_bank #(.N_IRQ(8), .SYNC_STAGES(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    irr_latch_bank #(.N_IRQ(16), .SYNC_STAGES(2)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input logic [7:0] w, input logic [7:0] le, input logic [7:0] m,
                       input logic av, input logic [2:0] id, input logic ca, input logic [7:0] raw);
        vec_t v;
        v.wires = w; v.le = le; v.mask = m; v.av = av; v.id = id; v.ca = ca; v.raw = raw;
        tv.push_back(v);
    endtask

    task automatic idle(input logic [7:0] w, input logic [7:0] raw);
        add(w, ALL_EDGE, 8'h00, 1'b0, 3'd0, 1'b0, raw);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus8.i_wires = 8'hFF; bus8.level_edge_flag = ALL_EDGE; bus8.mask = 8'h00;
        bus8.ack_valid = 1'b0; bus8.ack_id = 3'd0; bus8.clear_all = 1'b0;
        bus16.i_wires = 16'h0000; bus16.level_edge_flag = 16'hFFFF; bus16.mask = 16'h0000;
        bus16.ack_valid = 1'b0; bus16.ack_id = 4'd0; bus16.clear_all = 1'b0;
        // pins high with all channels in edge mode must never raise a request
        repeat (6) idle(8'hFF, 8'h00);
        repeat (4) idle(8'h00, 8'h00);
        // one-cycle pulse on ch3, held until its own ack
        idle(8'h08, 8'h00);
        idle(8'h00, 8'h00);
        repeat (3) idle(8'h00, 8'h08);
        add(8'h00, ALL_EDGE, 8'h00, 1'b1, 3'd2, 1'b0, 8'h08);
        add(8'h00, ALL_EDGE, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00);
        idle(8'h00, 8'h00);
        // level ch5 high for ten cycles, acks ignored
        for (int j = 0; j < 10; j++)
            add(8'h20, 8'hDF, 8'h00, j % 4 == 3, 3'd5, 1'b0, j < 2 ? 8'h00 : 8'h20);
        repeat (2) add(8'h00, 8'hDF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h20);
        repeat (2) add(8'h00, 8'hDF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
        idle(8'h00, 8'h00);
        // masked edge on ch0 stays latched, shows on IRR once unmasked, held pin never re-triggers
        add(8'h01, ALL_EDGE, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        add(8'h01, ALL_EDGE, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        repeat (2) add(8'h01, ALL_EDGE, 8'h01, 1'b0, 3'd0, 1'b0, 8'h01);
        idle(8'h01, 8'h01);
        add(8'h01, ALL_EDGE, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00);
        repeat (2) idle(8'h01, 8'h00);
        idle(8'h00, 8'h00);
        // ch2 rise coincident with ack of ch2 and clear_all: set wins, ch1 dropped
        idle(8'h02, 8'h00);
        idle(8'h00, 8'h00);
        idle(8'h00, 8'h02);
        idle(8'h04, 8'h02);
        idle(8'h00, 8'h02);
        add(8'h00, ALL_EDGE, 8'h00, 1'b1, 3'd2, 1'b1, 8'h04);
        add(8'h00, ALL_EDGE, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00);
        // clear_all alone
        idle(8'h10, 8'h00);
        idle(8'h00, 8'h00);
        idle(8'h00, 8'h10);
        add(8'h00, ALL_EDGE, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
        // leave ch0 latched under mask for the combinational mask check
        add(8'h01, ALL_EDGE, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        add(8'h00, ALL_EDGE, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
        add(8'h00, ALL_EDGE, 8'h01, 1'b0, 3'd0, 1'b0, 8'h01);

        #12;
        chk("rst raw8", 32'(bus8.irr_raw), 32'h0);
        chk("rst irr8", 32'(bus8.irr), 32'h0);
        chk("rst any8", 32'(bus8.irq_any), 32'h0);
        chk("rst raw16", 32'(bus16.irr_raw), 32'h0);
        cyc(1);
        chk("rst held raw8", 32'(bus8.irr_raw), 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < tv.size(); k++) begin
            bus8.i_wires = tv[k].wires;
            bus8.level_edge_flag = tv[k].le;
            bus8.mask = tv[k].mask;
            bus8.ack_valid = tv[k].av;
            bus8.ack_id = tv[k].id;
            bus8.clear_all = tv[k].ca;
            sb.push_back(tv[k]);
            cyc(1);
            e = sb.pop_front();
            chk($sformatf("v%0d raw", k), 32'(bus8.irr_raw), 32'(e.raw));
            chk($sformatf("v%0d irr", k), 32'(bus8.irr), 32'(e.raw & ~e.mask));
            chk($sformatf("v%0d any", k), 32'(bus8.irq_any), 32'(|(e.raw & ~e.mask)));
        end
        bus8.ack_valid = 1'b0;
        bus8.clear_all = 1'b0;

        // mask acts combinationally, no clock edge in between
        bus8.mask = 8'h00;
        #1;
        chk("unmask irr", 32'(bus8.irr), 32'h01);
        chk("unmask any", 32'(bus8.irq_any), 32'h1);
        bus8.mask = 8'h01;
        #1;
        chk("remask irr", 32'(bus8.irr), 32'h00);
        chk("remask any", 32'(bus8.irq_any), 32'h0);
        cyc(1);

        // 16-channel bank: ch15 edge, ack decode, mode flip while latched
        bus16.i_wires = 16'h8000;
        cyc(1);
        bus16.i_wires = 16'h0000;
        cyc(1);
        chk("p16 early", 32'(bus16.irr_raw), 32'h0);
        cyc(1);
        chk("p16 raw", 32'(bus16.irr_raw), 32'h8000);
        chk("p16 irr", 32'(bus16.irr), 32'h8000);
        chk("p16 any", 32'(bus16.irq_any), 32'h1);
        bus16.ack_valid = 1'b1; bus16.ack_id = 4'd14;
        cyc(1);
        chk("p16 ack14", 32'(bus16.irr_raw), 32'h8000);
        bus16.ack_id = 4'd15;
        cyc(1);
        bus16.ack_valid = 1'b0;
        chk("p16 ack15", 32'(bus16.irr_raw), 32'h0);
        bus16.i_wires = 16'h8000;
        cyc(1);
        bus16.i_wires = 16'h0000;
        cyc(2);
        chk("p16 relatch", 32'(bus16.irr_raw), 32'h8000);
        bus16.level_edge_flag = 16'h7FFF;
        cyc(1);
        chk("p16 flip", 32'(bus16.irr_raw), 32'h0);
        cyc(2);
        chk("p16 level low", 32'(bus16.irr_raw), 32'h0);
        bus16.level_edge_flag = 16'hFFFF;
        cyc(3);
        chk("p16 flip back", 32'(bus16.irr_raw), 32'h0);
        bus16.i_wires = 16'h8000;
        cyc(1);
        bus16.i_wires = 16'h0000;
        cyc(2);
        chk("p16 pend", 32'(bus16.irr_raw), 32'h8000);

        // asynchronous reset drops pending requests on both banks between edges
        bus8.mask = 8'h00;
        #1;
        chk("pre rst irr8", 32'(bus8.irr), 32'h01);
        bus8.i_wires = 8'hFF;
        rst_n = 1'b0;
        #1;
        chk("arst raw8", 32'(bus8.irr_raw), 32'h0);
        chk("arst irr8", 32'(bus8.irr), 32'h0);
        chk("arst any8", 32'(bus8.irq_any), 32'h0);
        chk("arst raw16", 32'(bus16.irr_raw), 32'h0);
        chk("arst any16", 32'(bus16.irq_any), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk($sformatf("rearm %0d", k), 32'(bus8.irr_raw), 32'h0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
